// File: rtl/cordic_vec_engine.sv
// Iterative vectoring-mode CORDIC: folds (x, y) into the right half-plane, drives y to zero
// over CORDIC_STAGES micro-rotations, then gain-compensates the magnitude and fixes up the angle.
module cordic_vec_engine #(
    parameter int DATA_WIDTH    = 32,
    parameter int CORDIC_WIDTH  = 38,
    parameter int CORDIC_STAGES = 32,
    parameter int ANGLE_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cordic_nrst,
    input  logic                          vec_en,
    input  logic signed [DATA_WIDTH-1:0]  vec_xin,
    input  logic signed [DATA_WIDTH-1:0]  vec_yin,
    input  logic                          vec_angle_calc_en,
    output logic                          vec_opvld,
    output logic signed [DATA_WIDTH-1:0]  vec_xout,
    output logic [CORDIC_STAGES-1:0]      vec_microRot_out,
    output logic [1:0]                    vec_quad_out,
    output logic                          vec_microRot_out_start,
    output logic signed [ANGLE_WIDTH-1:0] vec_angle_out
);
    localparam int IDX_W = $clog2(CORDIC_STAGES);
    localparam logic signed [63:0] KINV    = 64'sd636751;
    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_WIDTH - 1));
    localparam logic signed [ANGLE_WIDTH-1:0] PI = 32'sh6487ED51;

    typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

    // round(atan(2^-i) * 2^29); past i = 9 the cubic term no longer survives rounding
    function automatic logic signed [ANGLE_WIDTH-1:0] atan_lut(input logic [IDX_W-1:0] idx);
        logic signed [ANGLE_WIDTH-1:0] v;
        case (idx)
            5'd0:    v = 32'sh1921FB54;
            5'd1:    v = 32'sh0ED63383;
            5'd2:    v = 32'sh07D6DD7E;
            5'd3:    v = 32'sh03FAB753;
            5'd4:    v = 32'sh01FF55BB;
            5'd5:    v = 32'sh00FFEAAE;
            5'd6:    v = 32'sh007FFD55;
            5'd7:    v = 32'sh003FFFAB;
            5'd8:    v = 32'sh001FFFF5;
            5'd9:    v = 32'sh000FFFFF;
            default: v = (idx <= 5'd29) ? (32'sd1 <<< (5'd29 - idx)) : 32'sd0;
        endcase
        return v;
    endfunction

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                i_q, i_d;
    logic signed [CORDIC_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic signed [ANGLE_WIDTH-1:0]   z_q, z_d;
    logic [CORDIC_STAGES-1:0]        micro_q, micro_d;
    logic [1:0]                      quad_q, quad_d;
    logic                            ang_en_q, ang_en_d;
    logic                            armed_q, armed_d;
    logic signed [DATA_WIDTH-1:0]    xout_q, xout_d;
    logic [CORDIC_STAGES-1:0]        micro_out_q, micro_out_d;
    logic [1:0]                      quad_out_q, quad_out_d;
    logic signed [ANGLE_WIDTH-1:0]   angle_out_q, angle_out_d;
    logic signed [CORDIC_WIDTH-1:0]  xin_ext, yin_ext, x_sh, y_sh;
    logic signed [63:0]              scaled;

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        micro_d     = micro_q;
        quad_d      = quad_q;
        ang_en_d    = ang_en_q;
        armed_d     = armed_q;
        xout_d      = xout_q;
        micro_out_d = micro_out_q;
        quad_out_d  = quad_out_q;
        angle_out_d = angle_out_q;
        xin_ext     = CORDIC_WIDTH'(vec_xin);
        yin_ext     = CORDIC_WIDTH'(vec_yin);
        x_sh        = x_q >>> i_q;
        y_sh        = y_q >>> i_q;
        scaled      = (64'(x_q) * KINV) >>> 20;

        if (!cordic_nrst) begin
            state_d     = IDLE;
            i_d         = '0;
            x_d         = '0;
            y_d         = '0;
            z_d         = '0;
            micro_d     = '0;
            quad_d      = '0;
            ang_en_d    = 1'b0;
            armed_d     = 1'b1;
            xout_d      = '0;
            micro_out_d = '0;
            quad_out_d  = '0;
            angle_out_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (vec_en && armed_q) begin
                        quad_d   = {vec_xin[DATA_WIDTH-1], vec_yin[DATA_WIDTH-1]};
                        ang_en_d = vec_angle_calc_en;
                        // Left half-plane is rotated by pi so the iterations always converge
                        x_d      = vec_xin[DATA_WIDTH-1] ? -xin_ext : xin_ext;
                        y_d      = vec_xin[DATA_WIDTH-1] ? -yin_ext : yin_ext;
                        z_d      = '0;
                        i_d      = '0;
                        micro_d  = '0;
                        state_d  = ITER;
                    end
                end
                ITER: begin
                    if (!y_q[CORDIC_WIDTH-1]) begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_lut(i_q);
                        micro_d[i_q] = 1'b1;
                    end else begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_lut(i_q);
                        micro_d[i_q] = 1'b0;
                    end
                    i_d = i_q + 1'b1;
                    if (i_q == IDX_W'(CORDIC_STAGES - 1)) state_d = SCALE;
                end
                SCALE: begin
                    if (scaled > SAT_MAX)      xout_d = DATA_WIDTH'(SAT_MAX);
                    else if (scaled < SAT_MIN) xout_d = DATA_WIDTH'(SAT_MIN);
                    else                       xout_d = DATA_WIDTH'(scaled);
                    micro_out_d = micro_q;
                    quad_out_d  = quad_q;
                    if (!ang_en_q)             angle_out_d = '0;
                    else if (quad_q == 2'b10)  angle_out_d = z_q + PI;
                    else if (quad_q == 2'b11)  angle_out_d = z_q - PI;
                    else                       angle_out_d = z_q;
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
            // A held request must be released (or soft-cleared) before another accept
            if (state_q == SCALE) armed_d = 1'b0;
            if (!vec_en)          armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            micro_q     <= '0;
            quad_q      <= '0;
            ang_en_q    <= 1'b0;
            armed_q     <= 1'b1;
            xout_q      <= '0;
            micro_out_q <= '0;
            quad_out_q  <= '0;
            angle_out_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            micro_q     <= micro_d;
            quad_q      <= quad_d;
            ang_en_q    <= ang_en_d;
            armed_q     <= armed_d;
            xout_q      <= xout_d;
            micro_out_q <= micro_out_d;
            quad_out_q  <= quad_out_d;
            angle_out_q <= angle_out_d;
        end
    end

    assign vec_opvld              = (state_q == DONE);
    assign vec_microRot_out_start = (state_q == ITER) && (i_q == '0);
    assign vec_xout               = xout_q;
    assign vec_microRot_out       = micro_out_q;
    assign vec_quad_out           = quad_out_q;
    assign vec_angle_out          = angle_out_q;
endmodule
